inst_fifo: RTL and testbench

- Dual-write, dual-read instruction queue between fetch and the issue stage.
- Fetch pushes up to two {pc, inst} entries per cycle. Issue sees the two oldest entries through first-word-fall-through read ports and pops zero, one or two per cycle.
- Decouples fetch stalls from decode and absorbs branch flushes.

---
 rtl/inst_fifo_if.sv | 25 ++
 rtl/inst_fifo.sv | 87 ++++++++
 tb/tb_inst_fifo.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/inst_fifo_if.sv
// Fetch/issue-side signal bundle for inst_fifo: two write lanes, two FWFT read lanes, pops and flush.
interface inst_fifo_if;
   logic        flush;
   logic [63:0] w_data_1;
   logic        w_data_1_en;
   logic [63:0] w_data_2;
   logic        w_data_2_en;
   logic        fifo_full;
   logic [63:0] fifo_r_data_1;
   logic        fifo_r_data_1_ok;
   logic [63:0] fifo_r_data_2;
   logic        fifo_r_data_2_ok;
   logic        p_data_1;
   logic        p_data_2;

   modport master (
      output flush, w_data_1, w_data_1_en, w_data_2, w_data_2_en, p_data_1, p_data_2,
      input  fifo_full, fifo_r_data_1, fifo_r_data_1_ok, fifo_r_data_2, fifo_r_data_2_ok
   );

   modport slave (
      input  flush, w_data_1, w_data_1_en, w_data_2, w_data_2_en, p_data_1, p_data_2,
      output fifo_full, fifo_r_data_1, fifo_r_data_1_ok, fifo_r_data_2, fifo_r_data_2_ok
   );
endinterface

// File: rtl/inst_fifo.sv
// Dual-write, dual-read instruction queue between fetch and issue.
// Read ports fall through combinationally; accepted writes are compacted in age order.
module inst_fifo #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic       clk,
   input  logic       resetn,
   inst_fifo_if.slave fif
);
   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;

   localparam cnt_t FULL_LIM = cnt_t'(DEPTH - 2);

   logic [63:0] mem_q [DEPTH];
   ptr_t        head_q, head_d;
   ptr_t        tail_q, tail_d;
   cnt_t        count_q, count_d;
   ptr_t        head_p1, tail_p1;
   logic        ok1, ok2, full;
   logic        pop1, pop2;
   logic        wr0_en, wr1_en;
   logic [63:0] wr0_data;
   logic [1:0]  n_pop, n_push;

   assign head_p1 = head_q + ptr_t'(1);
   assign tail_p1 = tail_q + ptr_t'(1);

   assign ok1  = (count_q != '0);
   assign ok2  = (count_q > cnt_t'(1));
   assign full = (count_q > FULL_LIM);

   assign fif.fifo_full        = full;
   assign fif.fifo_r_data_1    = mem_q[head_q];
   assign fif.fifo_r_data_2    = mem_q[head_p1];
   assign fif.fifo_r_data_1_ok = ok1;
   assign fif.fifo_r_data_2_ok = ok2;

   assign pop1  = fif.p_data_1 & ok1;
   assign pop2  = fif.p_data_2 & ok2 & pop1;
   assign n_pop = {1'b0, pop1} + {1'b0, pop2};

   // Slot 0 takes the oldest valid lane; slot 1 is only used when both lanes are valid.
   assign wr0_en   = ~full & ~fif.flush & (fif.w_data_1_en | fif.w_data_2_en);
   assign wr1_en   = ~full & ~fif.flush & fif.w_data_1_en & fif.w_data_2_en;
   assign wr0_data = fif.w_data_1_en ? fif.w_data_1 : fif.w_data_2;
   assign n_push   = {1'b0, wr0_en} + {1'b0, wr1_en};

   always_comb begin
      head_d  = head_q + ptr_t'(n_pop);
      tail_d  = tail_q + ptr_t'(n_push);
      count_d = count_q + cnt_t'(n_push) - cnt_t'(n_pop);
      if (fif.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wr0_en) begin
            mem_q[tail_q] <= wr0_data;
         end
         if (wr1_en) begin
            mem_q[tail_p1] <= fif.w_data_2;
         end
      end
   end
endmodule

// File: tb/tb_inst_fifo.sv
// Directed vector bench for inst_fifo: table of per-cycle stimulus with hand-computed results,
// plus hand sequences for reset, same-cycle visibility and asynchronous mid-run reset.
module tb_inst_fifo;
   localparam int DEPTH = 16;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   inst_fifo_if fif ();

   inst_fifo #(.DEPTH(DEPTH), .PTR_W(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .fif    (fif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic [63:0] w1;
      logic        e1;
      logic [63:0] w2;
      logic        e2;
      logic        p1;
      logic        p2;
      int          cnt;
      logic        full;
      logic [63:0] d1;
      logic [63:0] d2;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [63:0] ent(input logic [31:0] pc, input logic [31:0] ins);
      return {pc, ins};
   endfunction

   function automatic logic [63:0] e_ent(input int k);
      return ent(32'h0000_1000 + 32'(4 * k), 32'(k));
   endfunction

   function automatic logic [63:0] h_ent(input int k);
      return ent(32'h0000_2000 + 32'(4 * k), 32'h0000_0100 + 32'(k));
   endfunction

   task automatic add(input logic fl, input logic [63:0] w1, input logic e1,
                      input logic [63:0] w2, input logic e2, input logic p1, input logic p2,
                      input int cnt, input logic full, input logic [63:0] d1, input logic [63:0] d2);
      vec_t v;
      v.fl = fl; v.w1 = w1; v.e1 = e1; v.w2 = w2; v.e2 = e2; v.p1 = p1; v.p2 = p2;
      v.cnt = cnt; v.full = full; v.d1 = d1; v.d2 = d2;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      fif.flush       = v.fl;
      fif.w_data_1    = v.w1;
      fif.w_data_1_en = v.e1;
      fif.w_data_2    = v.w2;
      fif.w_data_2_en = v.e2;
      fif.p_data_1    = v.p1;
      fif.p_data_2    = v.p2;
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, ".count"}, 64'(dut.count_q), 64'(v.cnt));
      chk({tag, ".full"}, 64'(fif.fifo_full), 64'(v.full));
      chk({tag, ".ok1"}, 64'(fif.fifo_r_data_1_ok), 64'(v.cnt >= 1));
      chk({tag, ".ok2"}, 64'(fif.fifo_r_data_2_ok), 64'(v.cnt >= 2));
      if (v.cnt >= 1) chk({tag, ".d1"}, fif.fifo_r_data_1, v.d1);
      if (v.cnt >= 2) chk({tag, ".d2"}, fif.fifo_r_data_2, v.d2);
   endtask

   task automatic step(input string tag, input vec_t v);
      drive(v);
      @(posedge clk);
      @(negedge clk);
      check_vec(tag, v);
   endtask

   // Occupancy must never leave [0, DEPTH].
   always @(negedge clk) begin
      if (resetn && (int'(dut.count_q) > DEPTH)) begin
         failures++;
         $display("FAIL count_bound: got %0d expected <= %0d", dut.count_q, DEPTH);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a, b, c, d, g, x, y, j;
      vec_t v;

      a = ent(32'hBFC0_0000, 32'h2401_0001);
      b = ent(32'hBFC0_0004, 32'h2402_0002);
      c = ent(32'h0000_0100, 32'h0000_0013);
      d = ent(32'h0000_0104, 32'h0020_0093);
      g = ent(32'h0000_0200, 32'h0000_0033);
      x = ent(32'hDEAD_0000, 32'hDEAD_BEEF);
      y = ent(32'hDEAD_0004, 32'hCAFE_F00D);
      j = ent(32'h0000_3000, 32'h1234_5678);

      //   fl  w1        e1  w2        e2  p1  p2  cnt full d1          d2
      add(0, a,        1, b,        1,  0,  0,  2,  0,  a,          b);          // 0
      add(0, '0,       0, '0,       0,  1,  0,  1,  0,  b,          '0);         // 1
      add(0, '0,       0, '0,       0,  1,  0,  0,  0,  '0,         '0);         // 2
      add(0, x,        0, c,        1,  0,  0,  1,  0,  c,          '0);         // 3
      add(0, d,        1, y,        0,  0,  0,  2,  0,  c,          d);          // 4
      add(0, '0,       0, '0,       0,  0,  1,  2,  0,  c,          d);          // 5
      add(0, '0,       0, '0,       0,  1,  1,  0,  0,  '0,         '0);         // 6
      add(0, g,        1, '0,       0,  0,  0,  1,  0,  g,          '0);         // 7
      add(0, '0,       0, '0,       0,  1,  0,  0,  0,  '0,         '0);         // 8
      for (int k = 0; k < 8; k++)                                                // 9..16
         add(0, e_ent(2*k), 1, e_ent(2*k+1), 1, 0, 0, 2*(k+1), (k == 7), e_ent(0), e_ent(1));
      add(0, x,        1, y,        1,  0,  0,  16, 1,  e_ent(0),   e_ent(1));   // 17
      add(0, '0,       0, '0,       0,  1,  1,  14, 0,  e_ent(2),   e_ent(3));   // 18
      add(0, e_ent(16),1, e_ent(17),1,  1,  1,  14, 0,  e_ent(4),   e_ent(5));   // 19
      add(0, '0,       0, '0,       0,  1,  1,  12, 0,  e_ent(6),   e_ent(7));   // 20
      add(0, '0,       0, '0,       0,  1,  1,  10, 0,  e_ent(8),   e_ent(9));   // 21
      add(0, '0,       0, '0,       0,  1,  1,  8,  0,  e_ent(10),  e_ent(11));  // 22
      add(0, '0,       0, '0,       0,  1,  1,  6,  0,  e_ent(12),  e_ent(13));  // 23
      add(1, x,        1, y,        1,  1,  1,  0,  0,  '0,         '0);         // 24
      for (int k = 0; k < 4; k++)                                                // 25..28
         add(0, h_ent(2*k), 1, h_ent(2*k+1), 1, 0, 0, 2*(k+1), 0, h_ent(0), h_ent(1));
      add(0, h_ent(8), 1, '0,       0,  0,  0,  9,  0,  h_ent(0),   h_ent(1));   // 29

      v.fl = 0; v.w1 = '0; v.e1 = 0; v.w2 = '0; v.e2 = 0; v.p1 = 0; v.p2 = 0;
      v.cnt = 0; v.full = 0; v.d1 = '0; v.d2 = '0;
      drive(v);

      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.ok1",  64'(fif.fifo_r_data_1_ok), 64'(0));
      chk("rst.ok2",  64'(fif.fifo_r_data_2_ok), 64'(0));
      chk("rst.full", 64'(fif.fifo_full), 64'(0));
      chk("rst.d1",   fif.fifo_r_data_1, 64'h0);
      chk("rst.d2",   fif.fifo_r_data_2, 64'h0);
      resetn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i == 0 || i == 3) begin
            // Pushes into an empty queue must not bypass to the read port before the edge.
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.no_bypass", i), 64'(fif.fifo_r_data_1_ok), 64'(0));
         end
         step($sformatf("v%0d", i), vecs[i]);
      end

      v.fl = 0; v.e1 = 0; v.e2 = 0; v.p1 = 0; v.p2 = 0;
      drive(v);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst.ok1",   64'(fif.fifo_r_data_1_ok), 64'(0));
      chk("mid_rst.ok2",   64'(fif.fifo_r_data_2_ok), 64'(0));
      chk("mid_rst.full",  64'(fif.fifo_full), 64'(0));
      chk("mid_rst.d1",    fif.fifo_r_data_1, 64'h0);
      chk("mid_rst.count", 64'(dut.count_q), 64'(0));
      @(negedge clk);
      resetn = 1'b1;

      v.w1 = j; v.e1 = 1; v.w2 = x; v.e2 = 0; v.cnt = 1; v.full = 0; v.d1 = j; v.d2 = '0;
      step("post_rst", v);

      v.e1 = 0; v.e2 = 0;
      drive(v);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
